bf_weight_sequencer: RTL and testbench
======================================

Name: bf_weight_sequencer

Overview:
- Controller that supplies the beamforming weight pair (bWeight_real/bWeight_imag) to the axis_multiplier datapath.
- Holds a double-buffered table of complex weights: a host-written shadow bank and a datapath-facing active bank.
- Applies all weight changes only on frame boundaries of the multiplier input stream, so a frame is never split across two weights.
- Supports a static hold mode and a beam-scan mode that steps through table entries every N frames.

Parameters:
WEIGHT_WIDTH, 8, width of each signed weight component
NUM_BEAMS, 16, table depth (power of two)
BEAM_IDX_W, 4, log2(NUM_BEAMS)
DWELL_W, 16, width of the frames-per-beam dwell setting
FCOUNT_W, 16, width of the frame counter

Ports:
clock  in  1  clock
resetn  in  1  reset, synchronous, active-low
cfg_wr_en  in  1  write one shadow-bank entry
cfg_wr_addr  in  BEAM_IDX_W  shadow entry index
cfg_wr_real  in  WEIGHT_WIDTH  signed real weight
cfg_wr_imag  in  WEIGHT_WIDTH  signed imag weight
cfg_commit  in  1  pulse: copy shadow bank to active bank at next boundary
cfg_mode  in  1  0 = HOLD, 1 = SCAN
cfg_beam_sel  in  BEAM_IDX_W  beam index used in HOLD
cfg_dwell  in  DWELL_W  frames per beam in SCAN (0 treated as 1)
cfg_scan_last  in  BEAM_IDX_W  last index of the scan range 0..cfg_scan_last
mon_tvalid  in  1  snoop of multiplier s_axis_real_tvalid
mon_tready  in  1  snoop of multiplier s_axis_real_tready
mon_tlast  in  1  snoop of multiplier s_axis_real_tlast
bWeight_real  out  WEIGHT_WIDTH  active real weight to multiplier
bWeight_imag  out  WEIGHT_WIDTH  active imag weight to multiplier
beam_idx  out  BEAM_IDX_W  index currently driving the weights
commit_pending  out  1  commit requested, not yet applied
commit_done  out  1  one-cycle pulse when the copy is applied
wr_drop  out  1  sticky: a cfg write was dropped
frame_count  out  FCOUNT_W  boundaries seen, wraps

Behaviour:
Frame boundary:
- A boundary (bnd) is any cycle with mon_tvalid && mon_tready && mon_tlast all high.

Reset (resetn = 0 at a clock edge):
- Both banks cleared to 0; state = IDLE.
- beam_idx, frame_count, dwell counter = 0.
- bWeight_real, bWeight_imag, commit_pending, commit_done, wr_drop = 0.
- Reset mid-frame discards any pending commit and all table contents.

Shadow writes:
- When cfg_wr_en = 1 and commit_pending = 0, entry cfg_wr_addr of the shadow bank is written at the clock edge.
- When cfg_wr_en = 1 and commit_pending = 1 (including the swap cycle), the write is dropped and wr_drop is set. wr_drop clears only on reset.

Commit:
- cfg_commit sets commit_pending on the next cycle. Repeat pulses while pending have no effect.
- On bnd with commit_pending = 1, all NUM_BEAMS entries are copied shadow to active in one cycle. In the same cycle: commit_pending clears, commit_done = 1 for one cycle.
- The shadow bank retains its contents after the copy.
- A cfg_commit coinciding with bnd while not pending applies at the following boundary, not this one.

State machine (mode sampled only on bnd):
- IDLE: weights output 0. On the first bnd, go to HOLD if cfg_mode = 0, else SCAN.
- HOLD: on each bnd, beam_idx <= cfg_beam_sel. cfg_mode = 1 moves to SCAN with beam_idx <= 0 and dwell counter <= 0.
- SCAN: on each bnd the dwell counter increments. When it reaches max(cfg_dwell,1) - 1:
  - the counter clears;
  - beam_idx <= (beam_idx >= cfg_scan_last) ? 0 : beam_idx + 1.
  - cfg_mode = 0 on a bnd moves to HOLD with beam_idx <= cfg_beam_sel.
- A commit and an index change on the same bnd both take effect together: the new index reads the newly copied table.

Output:
- bWeight_real/imag are registered copies of active[beam_idx], updated the cycle after each bnd or commit.
- Latency is one cycle. Beats accepted in the cycle immediately after bnd may still see the old weight; upstream must leave at least one idle cycle between frames.
- Outputs never change between boundaries, regardless of cfg_* activity.

Other:
- frame_count increments on every bnd in any non-reset state and wraps at 2^FCOUNT_W.
- Weights are passed through unmodified as signed two's complement. No arithmetic is performed on them.

Test Plan:
1. Reset, then write shadow[3] = (0x40, 0xC0), set cfg_beam_sel = 3, pulse commit, send 2 frames of 4 beats -> commit_done pulses at the first tlast beat; bWeight = 0x40/0xC0 from the next cycle; before that bWeight = 0.
2. In HOLD, change cfg_beam_sel 3->5 mid-frame -> beam_idx and weights change only one cycle after that frame's tlast handshake.
3. SCAN with cfg_dwell = 2, cfg_scan_last = 2, 8 frames -> beam_idx sequence per frame 0,0,1,1,2,2,0,0. With cfg_dwell = 0 -> index advances every frame.
4. Pulse commit, then cfg_wr_en to entry 1 before the boundary -> write dropped, wr_drop = 1 and stays 1; the active table after commit lacks the write.
5. mon_tlast = 1 with mon_tready = 0 for 3 cycles, then mon_tready = 1 -> exactly one boundary; frame_count += 1; pending commit applied only on the accepted beat.
6. Assert resetn = 0 while commit_pending = 1 in SCAN -> all outputs 0 next cycle; after release, the first boundary yields zero weights (cleared table).

Source files
------------

// File: rtl/bf_weight_sequencer.sv
// bf_weight_sequencer
//
// Purpose: supplies the complex beamforming weight (bWeight_real/bWeight_imag)
// to the axis_multiplier datapath. Keeps a host-written shadow table and a
// datapath-facing active table. Weight, index and table changes only take
// effect on frame boundaries of the snooped multiplier input stream, so a
// frame is never split across two weights. Supports HOLD (fixed beam) and
// SCAN (step through 0..cfg_scan_last every cfg_dwell frames).
//
// Ports:
//   clock, resetn            clock, synchronous active-low reset
//   cfg_wr_en/addr/real/imag shadow-table write port
//   cfg_commit               request shadow->active copy at next boundary
//   cfg_mode                 0 = HOLD, 1 = SCAN (sampled on boundaries)
//   cfg_beam_sel             beam used in HOLD
//   cfg_dwell                frames per beam in SCAN (0 behaves as 1)
//   cfg_scan_last            last index of the scan range
//   mon_tvalid/tready/tlast  snoop of the multiplier input handshake
//   bWeight_real/imag        registered active weight
//   beam_idx                 index currently driving the weights
//   commit_pending           commit requested, not yet applied
//   commit_done              one-cycle pulse when the copy is applied
//   wr_drop                  sticky: a write arrived while a commit was pending
//   frame_count              number of boundaries seen (wraps)
module bf_weight_sequencer #(
  parameter int WEIGHT_WIDTH = 8,
  parameter int NUM_BEAMS    = 16,
  parameter int BEAM_IDX_W   = 4,
  parameter int DWELL_W      = 16,
  parameter int FCOUNT_W     = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    cfg_wr_en,
  input  logic [BEAM_IDX_W-1:0]   cfg_wr_addr,
  input  logic [WEIGHT_WIDTH-1:0] cfg_wr_real,
  input  logic [WEIGHT_WIDTH-1:0] cfg_wr_imag,
  input  logic                    cfg_commit,
  input  logic                    cfg_mode,
  input  logic [BEAM_IDX_W-1:0]   cfg_beam_sel,
  input  logic [DWELL_W-1:0]      cfg_dwell,
  input  logic [BEAM_IDX_W-1:0]   cfg_scan_last,
  input  logic                    mon_tvalid,
  input  logic                    mon_tready,
  input  logic                    mon_tlast,
  output logic [WEIGHT_WIDTH-1:0] bWeight_real,
  output logic [WEIGHT_WIDTH-1:0] bWeight_imag,
  output logic [BEAM_IDX_W-1:0]   beam_idx,
  output logic                    commit_pending,
  output logic                    commit_done,
  output logic                    wr_drop,
  output logic [FCOUNT_W-1:0]     frame_count
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_SCAN
  } state_t;

  state_t state;
  state_t next_state;

  logic [WEIGHT_WIDTH-1:0] shadow_real [NUM_BEAMS];
  logic [WEIGHT_WIDTH-1:0] shadow_imag [NUM_BEAMS];
  logic [WEIGHT_WIDTH-1:0] active_real [NUM_BEAMS];
  logic [WEIGHT_WIDTH-1:0] active_imag [NUM_BEAMS];

  logic [DWELL_W-1:0]      dwell_cnt;
  logic [DWELL_W-1:0]      next_dwell;
  logic [DWELL_W-1:0]      dwell_lim;
  logic [BEAM_IDX_W-1:0]   next_idx;
  logic [WEIGHT_WIDTH-1:0] next_real;
  logic [WEIGHT_WIDTH-1:0] next_imag;
  logic                    bnd;
  logic                    apply;

  // Next index/state as they would be if this cycle is a boundary. The
  // weight lookup reads the shadow bank when a commit lands on the same
  // boundary, so a new index sees the freshly copied table.
  always_comb begin
    bnd        = mon_tvalid & mon_tready & mon_tlast;
    apply      = bnd & commit_pending;
    dwell_lim  = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
    next_state = state;
    next_idx   = beam_idx;
    next_dwell = dwell_cnt;
    case (state)
      S_IDLE, S_HOLD: begin
        if (cfg_mode) begin
          next_state = S_SCAN;
          next_idx   = '0;
          next_dwell = '0;
        end else begin
          next_state = S_HOLD;
          next_idx   = cfg_beam_sel;
        end
      end
      S_SCAN: begin
        if (!cfg_mode) begin
          next_state = S_HOLD;
          next_idx   = cfg_beam_sel;
        end else if (dwell_cnt >= dwell_lim) begin
          // >= rather than == keeps the scan moving if cfg_dwell shrinks mid-beam
          next_dwell = '0;
          next_idx   = (beam_idx >= cfg_scan_last) ? '0 : beam_idx + BEAM_IDX_W'(1);
        end else begin
          next_dwell = dwell_cnt + DWELL_W'(1);
        end
      end
      default: next_state = S_IDLE;
    endcase
    next_real = apply ? shadow_real[next_idx] : active_real[next_idx];
    next_imag = apply ? shadow_imag[next_idx] : active_imag[next_idx];
  end

  // All state, tables and registered outputs. Writes are refused while a
  // commit is pending so the bank being copied can never be half-updated.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_BEAMS; i++) begin
        shadow_real[i] <= '0;
        shadow_imag[i] <= '0;
        active_real[i] <= '0;
        active_imag[i] <= '0;
      end
      state          <= S_IDLE;
      beam_idx       <= '0;
      dwell_cnt      <= '0;
      frame_count    <= '0;
      bWeight_real   <= '0;
      bWeight_imag   <= '0;
      commit_pending <= 1'b0;
      commit_done    <= 1'b0;
      wr_drop        <= 1'b0;
    end else begin
      commit_done <= apply;
      if (apply) begin
        for (int i = 0; i < NUM_BEAMS; i++) begin
          active_real[i] <= shadow_real[i];
          active_imag[i] <= shadow_imag[i];
        end
        commit_pending <= 1'b0;
      end else if (cfg_commit) begin
        commit_pending <= 1'b1;
      end

      if (cfg_wr_en) begin
        if (commit_pending) begin
          wr_drop <= 1'b1;
        end else begin
          shadow_real[cfg_wr_addr] <= cfg_wr_real;
          shadow_imag[cfg_wr_addr] <= cfg_wr_imag;
        end
      end

      if (bnd) begin
        state        <= next_state;
        beam_idx     <= next_idx;
        dwell_cnt    <= next_dwell;
        bWeight_real <= next_real;
        bWeight_imag <= next_imag;
        frame_count  <= frame_count + FCOUNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_bf_weight_sequencer.sv
// tb_bf_weight_sequencer
//
// Purpose: scoreboard bench for bf_weight_sequencer. A driver issues directed
// and random stimulus and, after every clock edge, advances a frame-level
// reference model and queues the outputs it expects. A monitor pops one
// expectation per cycle on the falling edge and compares all outputs.
//
// Ports: none (top-level bench).
module tb_bf_weight_sequencer;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        cfg_wr_en = 1'b0;
  logic [3:0]  cfg_wr_addr = '0;
  logic [7:0]  cfg_wr_real = '0;
  logic [7:0]  cfg_wr_imag = '0;
  logic        cfg_commit = 1'b0;
  logic        cfg_mode = 1'b0;
  logic [3:0]  cfg_beam_sel = '0;
  logic [15:0] cfg_dwell = '0;
  logic [3:0]  cfg_scan_last = '0;
  logic        mon_tvalid = 1'b0;
  logic        mon_tready = 1'b0;
  logic        mon_tlast = 1'b0;
  logic [7:0]  bWeight_real;
  logic [7:0]  bWeight_imag;
  logic [3:0]  beam_idx;
  logic        commit_pending;
  logic        commit_done;
  logic        wr_drop;
  logic [15:0] frame_count;

  bf_weight_sequencer dut (
    .clock          (clock),
    .resetn         (resetn),
    .cfg_wr_en      (cfg_wr_en),
    .cfg_wr_addr    (cfg_wr_addr),
    .cfg_wr_real    (cfg_wr_real),
    .cfg_wr_imag    (cfg_wr_imag),
    .cfg_commit     (cfg_commit),
    .cfg_mode       (cfg_mode),
    .cfg_beam_sel   (cfg_beam_sel),
    .cfg_dwell      (cfg_dwell),
    .cfg_scan_last  (cfg_scan_last),
    .mon_tvalid     (mon_tvalid),
    .mon_tready     (mon_tready),
    .mon_tlast      (mon_tlast),
    .bWeight_real   (bWeight_real),
    .bWeight_imag   (bWeight_imag),
    .beam_idx       (beam_idx),
    .commit_pending (commit_pending),
    .commit_done    (commit_done),
    .wr_drop        (wr_drop),
    .frame_count    (frame_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0]  wr;
    logic [7:0]  wi;
    logic [3:0]  idx;
    logic        pend;
    logic        done;
    logic        drop;
    logic [15:0] fc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: tables, current beam, frames spent on it, mode.
  logic [7:0] sh_r[16], sh_i[16], ac_r[16], ac_i[16];
  int  m_mode;  // 0 idle, 1 hold, 2 scan
  int  m_idx, m_frames, m_fc;
  bit  m_pend, m_done, m_drop;
  logic [7:0] m_wr, m_wi;

  task automatic model_step();
    bit b, apply, was_pend;
    int lim;
    if (!resetn) begin
      for (int i = 0; i < 16; i++) begin
        sh_r[i] = 0; sh_i[i] = 0; ac_r[i] = 0; ac_i[i] = 0;
      end
      m_mode = 0; m_idx = 0; m_frames = 0; m_fc = 0;
      m_pend = 0; m_done = 0; m_drop = 0; m_wr = 0; m_wi = 0;
      return;
    end
    b        = mon_tvalid && mon_tready && mon_tlast;
    was_pend = m_pend;
    apply    = b && was_pend;
    if (apply) begin
      ac_r = sh_r;
      ac_i = sh_i;
    end
    m_done = apply;
    if (apply) m_pend = 0;
    else if (cfg_commit) m_pend = 1;
    if (cfg_wr_en) begin
      if (was_pend) m_drop = 1;
      else begin
        sh_r[cfg_wr_addr] = cfg_wr_real;
        sh_i[cfg_wr_addr] = cfg_wr_imag;
      end
    end
    if (b) begin
      if (m_mode != 2) begin
        if (cfg_mode) begin m_mode = 2; m_idx = 0; m_frames = 0; end
        else begin m_mode = 1; m_idx = int'(cfg_beam_sel); end
      end else if (!cfg_mode) begin
        m_mode = 1; m_idx = int'(cfg_beam_sel);
      end else begin
        lim = (cfg_dwell == 0) ? 1 : int'(cfg_dwell);
        m_frames++;
        if (m_frames >= lim) begin
          m_frames = 0;
          m_idx = (m_idx >= int'(cfg_scan_last)) ? 0 : m_idx + 1;
        end
      end
      m_wr = ac_r[m_idx];
      m_wi = ac_i[m_idx];
      m_fc = (m_fc + 1) % 65536;
    end
  endtask

  // One clock: the edge consumes the current inputs, the model follows and
  // queues what the DUT should show until the next edge.
  task automatic tick();
    exp_t e;
    @(posedge clock);
    model_step();
    e.wr = m_wr; e.wi = m_wi; e.idx = 4'(m_idx);
    e.pend = m_pend; e.done = m_done; e.drop = m_drop; e.fc = 16'(m_fc);
    exp_q.push_back(e);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per cycle, compared away from the active edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check_output("bWeight_real",   32'(bWeight_real),   32'(e.wr));
        check_output("bWeight_imag",   32'(bWeight_imag),   32'(e.wi));
        check_output("beam_idx",       32'(beam_idx),       32'(e.idx));
        check_output("commit_pending", 32'(commit_pending), 32'(e.pend));
        check_output("commit_done",    32'(commit_done),    32'(e.done));
        check_output("wr_drop",        32'(wr_drop),        32'(e.drop));
        check_output("frame_count",    32'(frame_count),    32'(e.fc));
      end
    end
  end

  task automatic cfg_write(input logic [3:0] a, input logic [7:0] r, input logic [7:0] i);
    cfg_wr_en = 1; cfg_wr_addr = a; cfg_wr_real = r; cfg_wr_imag = i;
    tick();
    cfg_wr_en = 0;
  endtask

  task automatic pulse_commit();
    cfg_commit = 1;
    tick();
    cfg_commit = 0;
  endtask

  task automatic send_frame(input int beats);
    for (int b = 0; b < beats; b++) begin
      mon_tvalid = 1; mon_tready = 1; mon_tlast = (b == beats - 1);
      tick();
    end
    mon_tvalid = 0; mon_tlast = 0;
    tick();
  endtask

  task automatic apply_stimulus();
    // Reset, load a few entries, commit, two frames in HOLD on beam 3.
    resetn = 0;
    repeat (3) tick();
    resetn = 1;
    tick();
    cfg_write(4'd3, 8'h40, 8'hC0);
    cfg_write(4'd5, 8'h11, 8'h22);
    cfg_write(4'd0, 8'h01, 8'hF1);
    cfg_write(4'd1, 8'h02, 8'hF2);
    cfg_write(4'd2, 8'h03, 8'hF3);
    cfg_beam_sel = 4'd3;
    pulse_commit();
    send_frame(4);
    send_frame(4);

    // Beam select changed mid-frame.
    mon_tvalid = 1; mon_tready = 1; mon_tlast = 0;
    tick(); tick();
    cfg_beam_sel = 4'd5;
    tick();
    mon_tlast = 1;
    tick();
    mon_tvalid = 0; mon_tlast = 0;
    tick();
    send_frame(3);

    // SCAN, dwell 2 over 0..2, then dwell 0.
    cfg_mode = 1; cfg_dwell = 16'd2; cfg_scan_last = 4'd2;
    for (int f = 0; f < 9; f++) send_frame(2);
    cfg_dwell = 16'd0;
    for (int f = 0; f < 5; f++) send_frame(2);

    // Write during a pending commit is dropped.
    cfg_mode = 0; cfg_beam_sel = 4'd1;
    pulse_commit();
    cfg_write(4'd1, 8'h77, 8'h88);
    tick();
    send_frame(2);
    send_frame(2);

    // Boundary held off by tready, pending commit waits for acceptance.
    cfg_write(4'd1, 8'h55, 8'h66);
    pulse_commit();
    mon_tvalid = 1; mon_tlast = 1; mon_tready = 0;
    repeat (3) tick();
    mon_tready = 1;
    tick();
    mon_tvalid = 0; mon_tlast = 0;
    tick();

    // Reset while a commit is pending in SCAN.
    cfg_mode = 1;
    send_frame(2);
    cfg_write(4'd0, 8'h99, 8'h9A);
    pulse_commit();
    tick();
    resetn = 0;
    tick();
    resetn = 1;
    tick();
    send_frame(2);
    send_frame(2);

    // Random traffic and configuration.
    for (int n = 0; n < 3000; n++) begin
      resetn      = ($urandom_range(0, 399) != 0);
      cfg_wr_en   = ($urandom_range(0, 3) == 0);
      cfg_wr_addr = 4'($urandom);
      cfg_wr_real = 8'($urandom);
      cfg_wr_imag = 8'($urandom);
      cfg_commit  = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 31) == 0) cfg_mode = ~cfg_mode;
      if ($urandom_range(0, 15) == 0) cfg_beam_sel = 4'($urandom);
      if ($urandom_range(0, 63) == 0) begin
        cfg_dwell     = 16'($urandom_range(0, 3));
        cfg_scan_last = 4'($urandom);
      end
      mon_tvalid = ($urandom_range(0, 3) != 0);
      mon_tready = ($urandom_range(0, 3) != 0);
      mon_tlast  = ($urandom_range(0, 3) == 0);
      tick();
    end
    resetn = 1; cfg_wr_en = 0; cfg_commit = 0; mon_tvalid = 0; mon_tlast = 0;
    tick();
  endtask

  initial begin
    apply_stimulus();
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d entries left expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: run did not complete in time");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
